// File: rtl/line_burst_adaptor.sv
// line_burst_adaptor
//   Memory-side responder for the cache pmem interface. One LINE_WIDTH line
//   read or write is accepted per request and completed as BEATS sequential
//   BURST_WIDTH beats to burst-mode memory. resp_o pulses for one cycle when
//   the line is finished.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   address_i         line address from the cache
//   line_i            write line from the cache (latched at accept)
//   read_i, write_i   line requests; read wins when both are high
//   line_o            assembled read line (holds last completed read)
//   resp_o            one-cycle completion pulse
//   address_o         line-aligned burst address
//   read_o, write_o   burst strobes to memory
//   burst_o           current write beat (0 outside a write)
//   burst_i           read beat from memory
//   resp_i            memory beat acknowledge, one beat per high cycle
//   timeout_o         sticky watchdog flag (LINE_BURST_ADAPTOR_TIMEOUT_EN only)
//
// Build option
//   LINE_BURST_ADAPTOR_TIMEOUT_EN: adds an idle-beat watchdog. After
//   TIMEOUT_CYCLES consecutive unacknowledged busy cycles the transfer is
//   abandoned (resp_o still pulses) and timeout_o latches high until rst.

module line_burst_adaptor #(
  parameter int LINE_WIDTH     = 256,
  parameter int BURST_WIDTH    = 64,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic [LINE_WIDTH-1:0]  line_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  output logic                   resp_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  output logic [BURST_WIDTH-1:0] burst_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  input  logic                   resp_i
`ifdef LINE_BURST_ADAPTOR_TIMEOUT_EN
  ,
  output logic                   timeout_o
`endif
);

  localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFS_W = $clog2(LINE_WIDTH / 8);

  localparam logic [CNT_W-1:0]      LAST_BEAT  = CNT_W'(BEATS - 1);
  // Clears the byte-within-line offset bits.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~((ADDR_WIDTH'(1) << OFS_W) - ADDR_WIDTH'(1));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Beat-sliced views of the read line and the captured write line.
  logic [BEATS-1:0][BURST_WIDTH-1:0] line_q;
  logic [BEATS-1:0][BURST_WIDTH-1:0] wbuf_q;
  logic [ADDR_WIDTH-1:0]             addr_q;

  logic busy;
  logic accept;
  logic wr_accept;
  logic abort;

  assign busy      = (state_q == READ) || (state_q == WRITE);
  assign accept    = (state_q == IDLE) && (read_i || write_i);
  assign wr_accept = (state_q == IDLE) && !read_i && write_i;

  // --------------------------------------------------------------------------
  // Optional watchdog: counts consecutive busy cycles without an acknowledge.
  // --------------------------------------------------------------------------
`ifdef LINE_BURST_ADAPTOR_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] stall_q;
  logic            to_q;

  // The cycle that would make the stall count reach TIMEOUT_CYCLES aborts.
  assign abort = busy && !resp_i && (stall_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      to_q    <= 1'b0;
    end else begin
      if (!busy || resp_i || abort) stall_q <= '0;
      else                          stall_q <= stall_q + TO_W'(1);
      if (abort) to_q <= 1'b1;
    end
  end

  assign timeout_o = to_q;
`else
  assign abort = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM state and beat counter.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;
    burst_o = '0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (read_i)       state_d = READ;
        else if (write_i) state_d = WRITE;
      end
      READ, WRITE: begin
        if (state_q == READ) begin
          read_o = 1'b1;
        end else begin
          write_o = 1'b1;
          burst_o = wbuf_q[cnt_q];
        end
        if (resp_i) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (abort) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        resp_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: address latch, write buffer, read line assembly.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      wbuf_q <= '0;
      line_q <= '0;
    end else begin
      if (accept) addr_q <= address_i & ALIGN_MASK;
      for (int b = 0; b < BEATS; b++) begin
        if (wr_accept)
          wbuf_q[b] <= line_i[b*BURST_WIDTH +: BURST_WIDTH];
        // Stall cycles leave the line untouched; beat 0 is least significant.
        if ((state_q == READ) && resp_i && (cnt_q == CNT_W'(b)))
          line_q[b] <= burst_i;
      end
    end
  end

  assign address_o = addr_q;
  assign line_o    = line_q;

endmodule

// File: tb/tb_line_burst_adaptor.sv
module tb_line_burst_adaptor;

  localparam int LW = 256;
  localparam int BW = 64;
  localparam int AW = 32;
  localparam int NB = LW / BW;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] address_i;
  logic [LW-1:0] line_i;
  logic          read_i, write_i;
  logic [LW-1:0] line_o;
  logic          resp_o;
  logic [AW-1:0] address_o;
  logic          read_o, write_o;
  logic [BW-1:0] burst_o;
  logic [BW-1:0] burst_i;
  logic          resp_i;
`ifdef LINE_BURST_ADAPTOR_TIMEOUT_EN
  logic          timeout_o;
`endif

  line_burst_adaptor #(
    .LINE_WIDTH(LW), .BURST_WIDTH(BW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .address_i(address_i), .line_i(line_i), .read_i(read_i), .write_i(write_i),
    .line_o(line_o), .resp_o(resp_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .burst_o(burst_o),
    .burst_i(burst_i), .resp_i(resp_i)
`ifdef LINE_BURST_ADAPTOR_TIMEOUT_EN
    , .timeout_o(timeout_o)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [LW-1:0] last_line;   // model: last completed read line

  typedef struct {
    bit            rd;
    bit            wr;
    logic [AW-1:0] addr;
    logic [AW-1:0] exp_addr;
    int            stall_pct;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One line transfer, entered and left at a negedge. The model: memory
  // sees strobes every busy cycle, beat k is the k-th acknowledged one, and
  // the line completes the cycle after the NB-th acknowledge.
  // pat_len>0 selects a fixed ack pattern (bit i = cycle i, then 1s).
  task automatic xfer(input bit rd, input bit wr, input logic [AW-1:0] addr,
                      input logic [AW-1:0] exp_addr, input logic [LW-1:0] wline,
                      input logic [LW-1:0] rdata, input logic [31:0] ack_pat,
                      input int pat_len, input int stall_pct);
    bit is_rd = rd;
    int beats = 0;
    int busy  = 0;
    int run   = 0;
    bit ack;
    bit done  = 0;
    read_i = rd; write_i = wr; address_i = addr; line_i = wline; resp_i = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      if (beats == NB) begin
        chk("resp_o pulse", 256'(resp_o), 256'(1));
        chk("read_o end", 256'(read_o), 256'(0));
        chk("write_o end", 256'(write_o), 256'(0));
        if (is_rd) last_line = rdata;
        chk("line_o", line_o, last_line);
        if (pat_len > 0) chk("busy cycles", 256'(busy), 256'(pat_len));
        read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        done = 1;
      end else begin
        busy++;
        chk("resp_o busy", 256'(resp_o), 256'(0));
        chk("read_o", 256'(read_o), 256'(is_rd));
        chk("write_o", 256'(write_o), 256'(!is_rd));
        chk("address_o", 256'(address_o), 256'(exp_addr));
        chk("burst_o", 256'(burst_o), is_rd ? 256'(0) : 256'(wline[beats*BW +: BW]));
        line_i = rnd_line();   // must be ignored after accept
        if (pat_len > 0) ack = (busy <= pat_len) ? ack_pat[busy-1] : 1'b1;
        else             ack = (run >= 5) ? 1'b1 : ($urandom_range(99) >= stall_pct);
        run     = ack ? 0 : run + 1;
        resp_i  = ack;
        burst_i = ack ? rdata[beats*BW +: BW] : BW'({$urandom, $urandom});
        if (ack) beats++;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL xfer completion: got no resp_o required within 200 cycles");
      read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    end
    @(negedge clk);
    chk("resp_o after", 256'(resp_o), 256'(0));
    chk("strobes after", 256'({read_o, write_o}), 256'(0));
  endtask

  initial begin
    logic [LW-1:0] d, r;
    rst = 1'b1; read_i = 0; write_i = 0; resp_i = 0;
    address_i = '0; line_i = '0; burst_i = '0;
    last_line = '0;
    #3;
    chk("reset resp_o", 256'(resp_o), 256'(0));
    chk("reset strobes", 256'({read_o, write_o}), 256'(0));
    chk("reset address_o", 256'(address_o), 256'(0));
    chk("reset line_o", line_o, 256'(0));
    chk("reset burst_o", 256'(burst_o), 256'(0));
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Fixed read: four back-to-back acks.
    r = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    xfer(1, 0, 32'h0000_1234, 32'h0000_1220, rnd_line(), r, 32'hF, 4, 0);

    // Fixed write: ack pattern 1,0,1,1,0,1 -> beats D0,D1,D1,D2,D3,D3.
    d = {64'hD3D3_0003_D3D3_0003, 64'hD2D2_0002_D2D2_0002,
         64'hD1D1_0001_D1D1_0001, 64'hD0D0_0000_D0D0_0000};
    xfer(0, 1, 32'h0000_0100, 32'h0000_0100, d, rnd_line(), 32'b101101, 6, 0);

    // Table: alignment boundaries, read priority, stall density.
    vt[0] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0000_0040, 0};
    vt[1] = '{1'b0, 1'b1, 32'h0000_001F, 32'h0000_0000, 40};
    vt[2] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFE0, 30};
    vt[3] = '{1'b0, 1'b1, 32'hABCD_EF3F, 32'hABCD_EF20, 60};
    vt[4] = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_0020, 0};
    vt[5] = '{1'b1, 1'b0, 32'h8000_001C, 32'h8000_0000, 50};
    for (int i = 0; i < 6; i++)
      xfer(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].exp_addr, rnd_line(), rnd_line(), 0, 0, vt[i].stall_pct);

    // Reset in the middle of a read after two beats.
    read_i = 1'b1; address_i = 32'h0000_0080;
    @(negedge clk);
    resp_i = 1'b1; burst_i = 64'hAAAA_BBBB_CCCC_DDDD;
    @(negedge clk);
    burst_i = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk);
    resp_i = 1'b0; read_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async rst read_o", 256'(read_o), 256'(0));
    chk("async rst resp_o", 256'(resp_o), 256'(0));
    chk("async rst address_o", 256'(address_o), 256'(0));
    chk("async rst line_o", line_o, 256'(0));
    chk("async rst burst_o", 256'(burst_o), 256'(0));
    last_line = '0;
    @(negedge clk);
    rst = 1'b0;
    xfer(1, 0, 32'h0000_0040, 32'h0000_0040, rnd_line(), rnd_line(), 32'hF, 4, 0);

    // resp_i activity while idle must do nothing.
    for (int i = 0; i < 10; i++) begin
      resp_i  = 1'($urandom_range(1));
      burst_i = BW'({$urandom, $urandom});
      @(negedge clk);
      chk("idle resp_o", 256'(resp_o), 256'(0));
      chk("idle read_o", 256'(read_o), 256'(0));
      chk("idle line_o", line_o, last_line);
    end
    resp_i = 1'b0;
    for (int i = 0; i < 3; i++)
      xfer(1, 0, 32'h0000_0200 + 32'(i*32), 32'h0000_0200 + 32'(i*32), rnd_line(), rnd_line(), 0, 0, 30);

    // Random mix against the model.
    for (int i = 0; i < 30; i++) begin
      bit rd, wr;
      logic [AW-1:0] a;
      rd = 1'($urandom_range(1));
      wr = rd ? 1'($urandom_range(1)) : 1'b1;
      a  = $urandom;
      xfer(rd, wr, a, a & 32'hFFFF_FFE0, rnd_line(), rnd_line(), 0, 0, $urandom_range(60));
    end

`ifdef LINE_BURST_ADAPTOR_TIMEOUT_EN
    // Write with no acknowledge: abort after 8 busy cycles.
    write_i = 1'b1; address_i = 32'h0000_0300; line_i = rnd_line(); resp_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("to write_o", 256'(write_o), 256'(1));
      chk("to resp_o early", 256'(resp_o), 256'(0));
      chk("to flag early", 256'(timeout_o), 256'(0));
    end
    @(negedge clk);
    write_i = 1'b0;
    chk("to write_o drop", 256'(write_o), 256'(0));
    chk("to resp_o pulse", 256'(resp_o), 256'(1));
    chk("to flag set", 256'(timeout_o), 256'(1));
    repeat (3) @(negedge clk);
    chk("to flag sticky", 256'(timeout_o), 256'(1));
    chk("to resp_o once", 256'(resp_o), 256'(0));
    chk("to line_o kept", line_o, last_line);
    #2 rst = 1'b1;
    #1 chk("to flag rst", 256'(timeout_o), 256'(0));
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
